// File: rtl/regfile_ctrl_pkg.sv
// Shared sizing defaults and FSM encoding for the register-file write path.
package regfile_ctrl_pkg;

  localparam int ADDR_W_DFLT = 5;
  localparam int DATA_W_DFLT = 4;
  localparam int DEPTH_DFLT  = 32;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin selector; "last" is 1 when requester 1 won the previous transfer.
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       enable,
  input  logic       last,
  output logic [1:0] grant,
  output logic       ptr_upd,
  output logic       ptr_next
);

  always_comb begin
    grant = 2'b00;
    if (enable) begin
      case (valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = last ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end

  // Every grant is an accepted transfer because requesters hold valid until ready.
  assign ptr_upd  = |grant;
  assign ptr_next = grant[1];

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Arbitrates two write requesters onto one register-file write port and runs a full-clear sweep.
module regfile_wr_arbiter
  import regfile_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DFLT,
  parameter int DATA_W = DATA_W_DFLT,
  parameter int DEPTH  = DEPTH_DFLT
) (
  input  logic              UserCLK,
  input  logic              RESETn,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  input  logic              clr_start,
  output logic              clr_busy,
  output logic              clr_done,
  output logic              W_en,
  output logic [ADDR_W-1:0] W_ADR,
  output logic [DATA_W-1:0] D
);

  state_t            state;
  logic              last;
  logic [ADDR_W-1:0] cnt;
  logic [1:0]        grant;
  logic              ptr_upd;
  logic              ptr_next;
  logic              enable;

  assign enable = (state == IDLE) && !clr_start;

  rr_arb2 u_rr_arb2 (
    .valid    ({req1_valid, req0_valid}),
    .enable   (enable),
    .last     (last),
    .grant    (grant),
    .ptr_upd  (ptr_upd),
    .ptr_next (ptr_next)
  );

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];

  always_ff @(posedge UserCLK or negedge RESETn) begin
    if (!RESETn) begin
      state    <= IDLE;
      last     <= 1'b1;
      cnt      <= '0;
      W_en     <= 1'b0;
      W_ADR    <= '0;
      D        <= '0;
      clr_busy <= 1'b0;
      clr_done <= 1'b0;
    end else begin
      W_en     <= 1'b0;
      clr_done <= 1'b0;
      case (state)
        IDLE: begin
          if (clr_start) begin
            state    <= CLEAR;
            cnt      <= '0;
            clr_busy <= 1'b1;
          end else if (ptr_upd) begin
            last  <= ptr_next;
            W_en  <= 1'b1;
            W_ADR <= grant[1] ? req1_addr : req0_addr;
            D     <= grant[1] ? req1_data : req0_data;
          end
        end
        CLEAR: begin
          // The pointer is untouched here so arbitration resumes where it left off.
          W_en  <= 1'b1;
          W_ADR <= cnt;
          D     <= '0;
          if (cnt == ADDR_W'(DEPTH - 1)) begin
            state    <= IDLE;
            clr_busy <= 1'b0;
            clr_done <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
